// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score keeper: default digit count, requester
// index constants, the BCD point values awarded to each requester, the
// controller state enum and a helper that pulls one BCD digit of a point
// value out for the digit-serial adder.
// ---------------------------------------------------------------------------
package score_pkg;

    localparam int DIGITS_DEFAULT = 4;

    localparam int REQ_DOT   = 0;
    localparam int REQ_POWER = 1;
    localparam int REQ_GHOST = 2;

    // Point values are held as two BCD digits; every higher digit is zero.
    localparam logic [7:0] PTS_DOT   = 8'h01;
    localparam logic [7:0] PTS_POWER = 8'h05;
    localparam logic [7:0] PTS_GHOST = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Return BCD digit 'digit' of the point value owed to requester
    // 'reqIdx'. Unknown requesters earn nothing.
    function automatic logic [3:0] pointDigit(input int reqIdx, input int digit);
        logic [7:0] pts;
        logic [3:0] result;
        pts    = 8'h00;
        result = 4'h0;
        case (reqIdx)
            REQ_DOT:   pts = PTS_DOT;
            REQ_POWER: pts = PTS_POWER;
            REQ_GHOST: pts = PTS_GHOST;
            default:   pts = 8'h00;
        endcase
        if (digit == 0) begin
            result = pts[3:0];
        end else if (digit == 1) begin
            result = pts[7:4];
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder, shared across all score digits by
// the score keeper.
//   a, b : BCD digits (0-9)
//   cin  : carry in from the previous digit
//   sum  : BCD result digit (0-9)
//   cout : carry out to the next digit
// ---------------------------------------------------------------------------
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] w_raw;
    logic [4:0] w_adj;

    // Binary sum of two BCD digits plus carry is at most 19; anything above
    // 9 wraps by subtracting ten and produces a decimal carry.
    assign w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    assign w_adj = w_raw - 5'd10;

    always_comb begin
        sum  = w_raw[3:0];
        cout = 1'b0;
        if (w_raw > 5'd9) begin
            sum  = w_adj[3:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// ---------------------------------------------------------------------------
// score_keeper
// Arcade-style BCD score keeper. Point-award requests from several sources
// are arbitrated (highest index wins), added one BCD digit per clock using a
// single shared digit adder, acknowledged, and committed. The displayed
// score only updates on frame boundaries so it never tears mid-frame.
//   clk_pix     : pixel clock, sole clock domain
//   rst_pix     : asynchronous active-high reset
//   clear       : synchronous new-game clear, overrides everything
//   frame_start : one-cycle pulse at the start of each video frame
//   req         : per-requester award request levels, held until acked
//   ack         : one-hot, one-cycle completion pulse
//   busy        : high while an award is being processed
//   score_disp  : frame-stable BCD score, digit 0 in the LSBs
//   sat         : sticky saturation flag
// ---------------------------------------------------------------------------
module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT,
    parameter int NREQ   = 3
) (
    input  logic                  clk_pix,
    input  logic                  rst_pix,
    input  logic                  clear,
    input  logic                  frame_start,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   score_disp,
    output logic                  sat
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int GNT_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    state_t              r_state;
    logic [GNT_W-1:0]    r_grant;
    logic [IDX_W-1:0]    r_idx;
    logic                r_carry;
    logic                r_ovf;
    logic [4*DIGITS-1:0] r_work;
    logic [4*DIGITS-1:0] r_committed;
    logic [4*DIGITS-1:0] r_disp;
    logic                r_sat;
    logic [NREQ-1:0]     r_ack;
    logic                r_busy;

    logic [GNT_W-1:0]    w_grantIdx;
    logic [NREQ-1:0]     w_grantOneHot;
    logic [3:0]          w_digitA;
    logic [3:0]          w_digitB;
    logic [3:0]          w_sum;
    logic                w_cout;

    // Fixed-priority arbiter: scanning upward lets the highest set index
    // overwrite lower ones, so ghost beats power beats dot.
    always_comb begin
        w_grantIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                w_grantIdx = GNT_W'(i);
            end
        end
    end

    assign w_grantOneHot = NREQ'(1) << r_grant;

    // The digit currently being worked on and the matching digit of the
    // granted point value feed the one shared adder.
    assign w_digitA = r_work[r_idx*4 +: 4];
    assign w_digitB = pointDigit(int'(r_grant), int'(r_idx));

    bcd_digit_add u_digitAdd (
        .a    (w_digitA),
        .b    (w_digitB),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Controller. IDLE grants a request and snapshots the committed score
    // into the working score; ADD walks the digits from least significant
    // upward carrying between them; ACK pulses the acknowledge and commits
    // the result (or all nines on overflow). The display register is
    // reloaded from the committed score only on frame_start, and because the
    // commit in ACK lands on the same edge, a coincident frame_start sees the
    // previous committed value. clear takes precedence over all of it, so an
    // award in flight is simply dropped without an ack.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_work      <= '0;
            r_committed <= '0;
            r_disp      <= '0;
            r_sat       <= 1'b0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
        end else if (clear) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_work      <= '0;
            r_committed <= '0;
            r_disp      <= '0;
            r_sat       <= 1'b0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (frame_start) begin
                r_disp <= r_committed;
            end
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (|req) begin
                        r_grant <= w_grantIdx;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                        r_work  <= r_committed;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_work[r_idx*4 +: 4] <= w_sum;
                    r_carry              <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_ovf   <= w_cout;
                        r_ack   <= w_grantOneHot;
                        r_state <= ACK;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ACK: begin
                    r_ack <= '0;
                    if (r_ovf) begin
                        r_committed <= ALL_NINES;
                        r_work      <= ALL_NINES;
                        r_sat       <= 1'b1;
                    end else begin
                        r_committed <= r_work;
                    end
                    r_idx   <= '0;
                    r_carry <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack        = r_ack;
    assign busy       = r_busy;
    assign score_disp = r_disp;
    assign sat        = r_sat;

endmodule

// File: tb/tb_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_score_keeper
// Directed bench for score_keeper with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_score_keeper;

    logic        clk_pix;
    logic        rst_pix;
    logic        clear;
    logic        frame_start;
    logic [2:0]  req;
    logic [2:0]  ack;
    logic        busy;
    logic [15:0] score_disp;
    logic        sat;

    int vectorsApplied;
    int miscompares;

    score_keeper #(
        .DIGITS (4),
        .NREQ   (3)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .clear       (clear),
        .frame_start (frame_start),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .score_disp  (score_disp),
        .sat         (sat)
    );

    // Free-running pixel clock; stimulus and sampling happen on the falling
    // edge, well away from the rising edge the design uses.
    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Wait up to 20 falling edges for any ack bit; lat is the number of
    // falling edges waited, or -1 when the bound expired.
    task automatic waitAck(output int lat, output logic [2:0] ackSeen);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_pix);
            if (ack != 3'b000) begin
                lat = i;
                break;
            end
        end
        ackSeen = ack;
    endtask

    // Raise one request, wait for its ack, drop it and step one more cycle
    // so the ack that follows can be checked for being a single pulse.
    task automatic applyStimulus(input int idx, output int lat,
                                 output logic [2:0] ackSeen,
                                 output logic [2:0] ackAfter);
        req[idx] = 1'b1;
        waitAck(lat, ackSeen);
        req[idx] = 1'b0;
        @(negedge clk_pix);
        ackAfter = ack;
    endtask

    task automatic pulseFrame();
        frame_start = 1'b1;
        @(negedge clk_pix);
        frame_start = 1'b0;
    endtask

    task automatic pulseClear();
        clear = 1'b1;
        @(negedge clk_pix);
        clear = 1'b0;
    endtask

    initial begin
        int         lat;
        int         badBulk;
        int         ackCount;
        logic [2:0] seen;
        logic [2:0] after;

        vectorsApplied = 0;
        miscompares    = 0;
        rst_pix        = 1'b1;
        clear          = 1'b0;
        frame_start    = 1'b0;
        req            = 3'b000;

        // Reset state
        repeat (2) @(negedge clk_pix);
        checkOutput("rstAck", 32'(ack), 32'h0);
        checkOutput("rstBusy", 32'(busy), 32'h0);
        checkOutput("rstDisp", 32'(score_disp), 32'h0);
        checkOutput("rstSat", 32'(sat), 32'h0);
        rst_pix = 1'b0;
        @(negedge clk_pix);

        // Single dot from 0000: ack five cycles after the grant cycle
        req[0] = 1'b1;
        @(negedge clk_pix);
        checkOutput("dotBusy", 32'(busy), 32'h1);
        waitAck(lat, seen);
        req[0] = 1'b0;
        checkOutput("dotLatency", 32'(lat), 32'd4);
        checkOutput("dotAck", 32'(seen), 32'h1);
        @(negedge clk_pix);
        checkOutput("dotAckPulse", 32'(ack), 32'h0);
        checkOutput("dotBusyDone", 32'(busy), 32'h0);
        checkOutput("dotDispHeld", 32'(score_disp), 32'h0);
        pulseFrame();
        checkOutput("dotDisp", 32'(score_disp), 32'h0001);

        // All three held: ghost, then power, then dot
        pulseClear();
        req = 3'b111;
        waitAck(lat, seen);
        req[2] = 1'b0;
        checkOutput("prioLat0", 32'(lat), 32'd5);
        checkOutput("prioGhost", 32'(seen), 32'h4);
        waitAck(lat, seen);
        req[1] = 1'b0;
        checkOutput("prioLat1", 32'(lat), 32'd6);
        checkOutput("prioPower", 32'(seen), 32'h2);
        waitAck(lat, seen);
        req[0] = 1'b0;
        checkOutput("prioDot", 32'(seen), 32'h1);
        @(negedge clk_pix);
        pulseFrame();
        checkOutput("prioScore", 32'(score_disp), 32'h0026);

        // Build 0019 then add power across the digit boundary
        pulseClear();
        badBulk = 0;
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1, lat, seen, after);
            if (lat != 5 || seen != 3'b010 || after != 3'b000) badBulk++;
        end
        for (int n = 0; n < 4; n++) begin
            applyStimulus(0, lat, seen, after);
            if (lat != 5 || seen != 3'b001 || after != 3'b000) badBulk++;
        end
        pulseFrame();
        checkOutput("score19", 32'(score_disp), 32'h0019);
        applyStimulus(1, lat, seen, after);
        pulseFrame();
        checkOutput("score24", 32'(score_disp), 32'h0024);

        // Climb to 9999 exactly, then overflow with a ghost
        pulseClear();
        for (int n = 0; n < 499; n++) begin
            applyStimulus(2, lat, seen, after);
            if (lat != 5 || seen != 3'b100 || after != 3'b000) badBulk++;
        end
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1, lat, seen, after);
            if (lat != 5 || seen != 3'b010) badBulk++;
        end
        for (int n = 0; n < 4; n++) begin
            applyStimulus(0, lat, seen, after);
            if (lat != 5 || seen != 3'b001) badBulk++;
        end
        checkOutput("bulkAwards", 32'(badBulk), 32'd0);
        pulseFrame();
        checkOutput("score9999", 32'(score_disp), 32'h9999);
        checkOutput("satNotYet", 32'(sat), 32'h0);
        applyStimulus(2, lat, seen, after);
        pulseFrame();
        checkOutput("satScore", 32'(score_disp), 32'h9999);
        checkOutput("satFlag", 32'(sat), 32'h1);
        applyStimulus(0, lat, seen, after);
        pulseFrame();
        checkOutput("satSticky", 32'(sat), 32'h1);
        checkOutput("satHold", 32'(score_disp), 32'h9999);

        // clear in the middle of an add: no ack, held req restarts from 0
        req[1] = 1'b1;
        repeat (2) @(negedge clk_pix);
        pulseClear();
        checkOutput("clrDisp", 32'(score_disp), 32'h0);
        checkOutput("clrSat", 32'(sat), 32'h0);
        checkOutput("clrAck", 32'(ack), 32'h0);
        checkOutput("clrBusy", 32'(busy), 32'h0);
        waitAck(lat, seen);
        req[1] = 1'b0;
        checkOutput("clrReqLat", 32'(lat), 32'd5);
        checkOutput("clrReqAck", 32'(seen), 32'h2);
        @(negedge clk_pix);
        pulseFrame();
        checkOutput("clrScore", 32'(score_disp), 32'h0005);

        // Mid-frame completion leaves the display alone until frame_start
        applyStimulus(0, lat, seen, after);
        repeat (3) @(negedge clk_pix);
        checkOutput("midFrameHold", 32'(score_disp), 32'h0005);
        pulseFrame();
        checkOutput("midFrameShow", 32'(score_disp), 32'h0006);

        // frame_start in the ACK cycle shows the value before the commit
        req[0] = 1'b1;
        waitAck(lat, seen);
        frame_start = 1'b1;
        req[0]      = 1'b0;
        @(negedge clk_pix);
        frame_start = 1'b0;
        checkOutput("coincidentOld", 32'(score_disp), 32'h0006);
        pulseFrame();
        checkOutput("coincidentNext", 32'(score_disp), 32'h0007);

        // Asynchronous reset in the middle of an add
        req[0] = 1'b1;
        repeat (2) @(negedge clk_pix);
        #2 rst_pix = 1'b1;
        #1;
        checkOutput("asyncBusy", 32'(busy), 32'h0);
        checkOutput("asyncAck", 32'(ack), 32'h0);
        checkOutput("asyncDisp", 32'(score_disp), 32'h0);
        checkOutput("asyncSat", 32'(sat), 32'h0);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        req[0]  = 1'b0;
        ackCount = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk_pix);
            if (ack != 3'b000) ackCount++;
        end
        checkOutput("noSpuriousAck", 32'(ackCount), 32'd0);
        pulseFrame();
        checkOutput("afterRstDisp", 32'(score_disp), 32'h0);

        // Normal service resumes after reset
        applyStimulus(2, lat, seen, after);
        checkOutput("resumeLat", 32'(lat), 32'd5);
        checkOutput("resumeAck", 32'(seen), 32'h4);
        pulseFrame();
        checkOutput("resumeScore", 32'(score_disp), 32'h0020);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    // Global time bound so the run always ends even if an ack never comes.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed running, expected finished");
        $fatal(1, "[TB] time limit");
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD score digits.
REQ-002 SHALL have parameter NREQ, default 3, number of point-event requesters (0=dot, 1=power pellet, 2=ghost).
REQ-003 SHALL have port clk_pix  input  1  pixel clock, sole clock domain.
REQ-004 SHALL have port rst_pix  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous new-game clear.
REQ-006 SHALL have port frame_start  input  1  one-cycle pulse at start of each video frame.
REQ-007 SHALL have port req  input  NREQ  point-award requests, level, held until acked.
REQ-008 SHALL have port ack  output  NREQ  one-hot, one-cycle completion pulse per request.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port score_disp  output  4*DIGITS  frame-stable BCD score; digit 0 in the LSBs.
REQ-011 SHALL have port sat  output  1  sticky saturation flag.

Function
REQ-012 SHALL implement states IDLE, ADD, ACK.
REQ-013 In IDLE with any req bit high, SHALL grant the highest index set (ghost > power > dot), latch the grant, load the digit index to 0, and go to ADD.
REQ-014 In ADD, SHALL add one BCD digit per cycle: working digit[i] + points digit[i] + carry, giving a result digit 0-9 and a carry out; i runs 0..DIGITS-1.
REQ-015 After digit DIGITS-1, SHALL go to ACK; total req-to-ack latency SHALL be DIGITS+1 cycles after the IDLE grant cycle (ack in cycle DIGITS+1 for a req first seen in cycle 0).
REQ-016 In ACK, SHALL pulse ack[grant] for exactly one cycle, copy the working score to the committed score, and return to IDLE.
REQ-017 A requester SHALL deassert req in the cycle after ack; req still high when IDLE re-samples is a new award.
REQ-018 Requests arriving while busy SHALL wait; there is no queueing beyond held req levels.
REQ-019 Point values SHALL be BCD constants: dot 0001, power 0005, ghost 0020.
REQ-020 If the final carry out of digit DIGITS-1 is 1, the committed score SHALL be all 9s and sat SHALL set; sat stays high until clear or reset.
REQ-021 On a frame_start pulse, score_disp SHALL load the committed score, taking effect the next cycle; score_disp SHALL not change at any other time except on clear.
REQ-022 frame_start coincident with ACK SHALL load the pre-ACK committed value.
REQ-023 clear SHALL override all other activity: working score, committed score, score_disp and sat go to 0; state goes to IDLE; no ack is issued for an aborted add.
REQ-024 Requests still held after clear SHALL be serviced normally from score 0.
REQ-025 ack SHALL be 0 in every state except ACK.

Reset
REQ-026 While rst_pix is high, SHALL set: state IDLE, ack 0, busy 0, sat 0, score_disp 0, working and committed scores 0, grant 0, digit index 0.
REQ-027 Reset assertion mid-ADD SHALL abandon the add with no ack.
REQ-028 Operation SHALL resume from IDLE on the first clk_pix edge after rst_pix deasserts.

Structure
REQ-029 Package score_pkg SHALL hold DIGITS default, requester index constants, BCD point constants and the state enum.
REQ-030 Sub-module bcd_digit_add SHALL implement the combinational 1-digit BCD add (a, b, cin -> sum, cout), instantiated once and time-shared across the digits.

Verification
REQ-031 Dot req at score 0000 -> ack[0] pulse 5 cycles after the grant cycle; committed score 0001; score_disp 0001 after the next frame_start.
REQ-032 req=3'b111 held, each bit dropped after its ack -> ack order ghost, power, dot; final score 0026.
REQ-033 Score 0019 + power -> 0024 (carry across a digit boundary); score 9999 + ghost -> 9999 and sat=1.
REQ-034 clear during ADD -> no ack; score_disp=0 and sat=0 next cycle; held req then acked with score = its point value.
REQ-035 Award completes mid-frame -> score_disp unchanged until frame_start, then shows the new value; frame_start coincident with ACK shows the old value.
REQ-036 rst_pix pulsed asynchronously mid-ADD -> all outputs 0 immediately; no spurious ack after release.
